pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the RISC-V fetch stage; the next generation of the basic single-step PC register. Adds a configurable reset vector and width, a valid/ready handshake to instruction fetch, trap redirection above jump/branch, misaligned-target detection with a halt state, and a fetch-flush pulse. Sits between the execute-stage redirect logic and the instruction-memory fetch port.

## Interface
- XLEN, 32, PC and target width in bits (≥ 8)
- RESET_VEC, {XLEN{1'b0}}, PC value loaded on reset; must satisfy the alignment rule below

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- pc_ready  in  1  fetch accepts the current pc this cycle
- branch_taken  in  1  conditional branch resolved taken
- branch_tgt  in  XLEN  branch target
- jump  in  1  unconditional jump (JAL/JALR)
- jump_tgt  in  XLEN  jump target
- trap  in  1  exception/interrupt redirect
- trap_tgt  in  XLEN  trap handler address
- inst_16  in  1  current instruction is 16-bit (present only with PC_RVC_EN)
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is valid for fetch
- flush  out  1  one-cycle pulse: discard in-flight fetches
- misalign  out  1  one-cycle pulse: rejected misaligned jump/branch target
- bad_addr  out  XLEN  last rejected target (holds until next rejection or reset)

## Operation
- States: BOOT, RUN, HALT. All outputs registered.
- Reset (reset==0): state=BOOT, pc=RESET_VEC, pc_valid=0, flush=0, misalign=0, bad_addr=0.
- BOOT: one-cycle bubble; next edge → RUN, pc_valid=1, pc unchanged. A trap in BOOT is taken (as in RUN).
- RUN, priority trap > jump > branch_taken > sequential:
  - trap: pc<=trap_tgt with low alignment bits forced to 0 (never faults), flush=1.
  - jump / branch_taken, target aligned: pc<=target, flush=1.
  - jump / branch_taken, target misaligned: pc held, pc_valid<=0, misalign=1, bad_addr<=target, state → HALT.
  - no redirect, pc_valid && pc_ready (fire): pc<=pc+step.
  - no redirect, no fire: everything held.
- Redirects take effect regardless of pc_ready.
- HALT: pc_valid=0; jump and branch_taken ignored; trap → pc<=aligned trap_tgt, flush=1, pc_valid=1, state → RUN.
- Arithmetic: pc+step is modulo 2^XLEN (wrap-around with no flag).
- Alignment without PC_RVC_EN: step=4; target[1:0] must be 00.

## Timing
- Redirect and increment are visible on pc one cycle after the sampling edge.
- flush and misalign assert in the same cycle as the corresponding pc/state update, for exactly one cycle.
- Latency from reset release to first pc_valid=1 is one clock.
- Reset asserted mid-operation (any state) immediately forces reset values asynchronously.

## Configuration
- PC_RVC_EN defined: compressed-ISA support. The inst_16 port exists. step=2 when inst_16=1, otherwise 4. A target is misaligned only if target[0]=1. trap_tgt[0] is forced to 0.
- PC_RVC_EN undefined: inst_16 is absent, step=4, and word alignment (target[1:0]==00) is required. trap_tgt[1:0] is forced to 00.

## Test plan
- Reset with RESET_VEC=0x80: pc=0x80 and pc_valid=0 while reset=0. One cycle after release, pc_valid=1 with pc=0x80.
- Sequential run with pc_ready toggling 1,0,1: pc goes 0x80→0x84, holds at 0x84, then goes to 0x88. flush stays 0 throughout.
- Simultaneous jump (0x400), branch_taken (0x300) and trap (0x203): next pc=0x200 with flush=1. Jump 0x400 with branch 0x300: pc=0x400.
- Misaligned jump to 0x102 (no RVC): misalign pulses, bad_addr=0x102, pc_valid=0 and pc held. A later branch to 0x300 is ignored. A trap to 0x500 then yields pc=0x500, pc_valid=1 and flush=1.
- Wrap-around: pc=0xFFFFFFFC with fire → pc=0x00000000. Reset asserted while in HALT → BOOT state and reset values.
- With PC_RVC_EN: inst_16=1 at 0x100 → pc=0x102. A jump to 0x106 is accepted. A jump to 0x107 gives misalign, with bad_addr=0x107.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: reset vector, valid/ready fetch
// handshake, trap/jump/branch redirect, misaligned-target halt. Option: PC_RVC_EN.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_tgt,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_tgt,
`ifdef PC_RVC_EN
  input  logic            inst_16,
`endif
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  // state | meaning
  // BOOT  | one-cycle bubble after reset, pc_valid low
  // RUN   | fetching; redirects and increments applied
  // HALT  | misaligned target rejected; only a trap restarts fetch
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

`ifdef PC_RVC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(1));
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
`endif

  state_t          state, state_n;
  logic [XLEN-1:0] pc_n, bad_n, step, redir_tgt;
  logic            valid_n, flush_n, mis_n, redir, redir_bad;

`ifdef PC_RVC_EN
  assign step = inst_16 ? XLEN'(2) : XLEN'(4);
`else
  assign step = XLEN'(4);
`endif

  assign redir     = jump | branch_taken;
  assign redir_tgt = jump ? jump_tgt : branch_tgt;
  assign redir_bad = |(redir_tgt & ~ALIGN_MASK);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = pc_valid;
    flush_n = 1'b0;
    mis_n   = 1'b0;
    bad_n   = bad_addr;
    case (state)
      BOOT: begin
        state_n = RUN;
        valid_n = 1'b1;
        if (trap) begin
          pc_n    = trap_tgt & ALIGN_MASK;
          flush_n = 1'b1;
        end
      end
      RUN: begin
        if (trap) begin
          pc_n    = trap_tgt & ALIGN_MASK;
          flush_n = 1'b1;
        end else if (redir && redir_bad) begin
          valid_n = 1'b0;
          mis_n   = 1'b1;
          bad_n   = redir_tgt;
          state_n = HALT;
        end else if (redir) begin
          pc_n    = redir_tgt;
          flush_n = 1'b1;
        end else if (pc_valid && pc_ready) begin
          pc_n = pc + step;
        end
      end
      HALT: begin
        valid_n = 1'b0;
        if (trap) begin
          pc_n    = trap_tgt & ALIGN_MASK;
          flush_n = 1'b1;
          valid_n = 1'b1;
          state_n = RUN;
        end
      end
      default: begin
        state_n = BOOT;
        pc_n    = RESET_VEC;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pc_valid <= valid_n;
      flush    <= flush_n;
      misalign <= mis_n;
      bad_addr <= bad_n;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen with RESET_VEC=0x80; the compressed-ISA
// steps run instead of the word-alignment steps when PC_RVC_EN is defined.
module tb_pc_gen;

  localparam int XLEN = 32;
  localparam logic [31:0] RV = 32'h80;
`ifdef PC_RVC_EN
  localparam logic [31:0] BAD_LAST = 32'h107;
`else
  localparam logic [31:0] BAD_LAST = 32'h502;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_tgt = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_tgt = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_tgt = '0;
`ifdef PC_RVC_EN
  logic        inst_16 = 1'b0;
`endif
  logic [31:0] pc, bad_addr;
  logic        pc_valid, flush, misalign;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RV)) dut (
    .clk(clk), .reset(reset), .pc_ready(pc_ready),
    .branch_taken(branch_taken), .branch_tgt(branch_tgt),
    .jump(jump), .jump_tgt(jump_tgt), .trap(trap), .trap_tgt(trap_tgt),
`ifdef PC_RVC_EN
    .inst_16(inst_16),
`endif
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .misalign(misalign),
    .bad_addr(bad_addr)
  );

  task automatic push(input string tag, input logic [31:0] epc, input logic ev,
                      input logic ef, input logic em, input logic [31:0] eb);
    exp_t e;
    e.tag = tag; e.pc = epc; e.valid = ev; e.flush = ef; e.mis = em; e.bad = eb;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    assert (pc === e.pc) else begin
      miscompares++; $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc, e.pc);
    end
    assert (pc_valid === e.valid) else begin
      miscompares++; $error("FAIL %s.pc_valid observed=%b expected=%b", e.tag, pc_valid, e.valid);
    end
    assert (flush === e.flush) else begin
      miscompares++; $error("FAIL %s.flush observed=%b expected=%b", e.tag, flush, e.flush);
    end
    assert (misalign === e.mis) else begin
      miscompares++; $error("FAIL %s.misalign observed=%b expected=%b", e.tag, misalign, e.mis);
    end
    assert (bad_addr === e.bad) else begin
      miscompares++; $error("FAIL %s.bad_addr observed=%h expected=%h", e.tag, bad_addr, e.bad);
    end
  endtask

  // Drive one cycle of inputs, record the expectation, then check after the edge.
  task automatic run(input string tag, input logic rdy,
                     input logic tr, input logic [31:0] tt,
                     input logic jp, input logic [31:0] jt,
                     input logic br, input logic [31:0] bt,
                     input logic [31:0] epc, input logic ev, input logic ef,
                     input logic em, input logic [31:0] eb);
    pc_ready = rdy; trap = tr; trap_tgt = tt;
    jump = jp; jump_tgt = jt; branch_taken = br; branch_tgt = bt;
    push(tag, epc, ev, ef, em, eb);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string tag, input logic [31:0] epc, input logic ev,
                           input logic ef, input logic em, input logic [31:0] eb);
    push(tag, epc, ev, ef, em, eb);
    compare();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_now("rst", RV, 0, 0, 0, 0);
    reset = 1'b1;
    //   tag          rdy tr tt            jp jt       br bt       pc            v f m bad
    run("boot",       1,  0, 0,            0, 0,       0, 0,       RV,           1,0,0,0);
    run("seq1",       1,  0, 0,            0, 0,       0, 0,       32'h84,       1,0,0,0);
    run("hold",       0,  0, 0,            0, 0,       0, 0,       32'h84,       1,0,0,0);
    run("seq2",       1,  0, 0,            0, 0,       0, 0,       32'h88,       1,0,0,0);
    run("prio_trap",  0,  1, 32'h203,      1, 32'h400, 1, 32'h300, 32'h200,      1,1,0,0);
    run("idle",       0,  0, 0,            0, 0,       0, 0,       32'h200,      1,0,0,0);
    run("prio_jmp",   0,  0, 0,            1, 32'h400, 1, 32'h300, 32'h400,      1,1,0,0);
    run("br",         1,  0, 0,            0, 0,       1, 32'h300, 32'h300,      1,1,0,0);
`ifdef PC_RVC_EN
    run("rvc_trap",   0,  1, 32'h100,      0, 0,       0, 0,       32'h100,      1,1,0,0);
    inst_16 = 1'b1;
    run("rvc_seq16",  1,  0, 0,            0, 0,       0, 0,       32'h102,      1,0,0,0);
    run("rvc_jmp106", 1,  0, 0,            1, 32'h106, 0, 0,       32'h106,      1,1,0,0);
    run("rvc_jmp107", 1,  0, 0,            1, 32'h107, 0, 0,       32'h106,      0,0,1,32'h107);
    run("rvc_trap2",  1,  1, 32'h101,      0, 0,       0, 0,       32'h100,      1,1,0,32'h107);
    inst_16 = 1'b0;
`else
    run("mis_jmp",    1,  0, 0,            1, 32'h102, 0, 0,       32'h300,      0,0,1,32'h102);
    run("halt_idle",  1,  0, 0,            0, 0,       0, 0,       32'h300,      0,0,0,32'h102);
    run("halt_br",    1,  0, 0,            0, 0,       1, 32'h300, 32'h300,      0,0,0,32'h102);
    run("halt_trap",  1,  1, 32'h500,      0, 0,       0, 0,       32'h500,      1,1,0,32'h102);
    run("mis_br",     1,  0, 0,            0, 0,       1, 32'h502, 32'h500,      0,0,1,32'h502);
`endif
    run("wrap_trap",  0,  1, 32'hFFFFFFFD, 0, 0,       0, 0,       32'hFFFFFFFC, 1,1,0,BAD_LAST);
    run("wrap",       1,  0, 0,            0, 0,       0, 0,       32'h0,        1,0,0,BAD_LAST);
    run("mis13",      1,  0, 0,            1, 32'h13,  0, 0,       32'h0,        0,0,1,32'h13);
    reset = 1'b0;
    #1;
    check_now("rst_halt", RV, 0, 0, 0, 0);
    run("rst_hold",   1,  0, 0,            0, 0,       0, 0,       RV,           0,0,0,0);
    reset = 1'b1;
    run("reboot",     1,  0, 0,            0, 0,       0, 0,       RV,           1,0,0,0);
    run("reseq",      1,  0, 0,            0, 0,       0, 0,       32'h84,       1,0,0,0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
